instr_decoder: RTL and testbench
================================

INSTR_DECODER -- requirements
Module: instr_decoder

Interface
REQ-001 Parameter: REG_ADDR_W, 5, register-address width for rs1_addr/rs2_addr/rd_addr.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  upstream presents instr.
REQ-005 in_ready  output  1  decoder accepts instr this cycle.
REQ-006 instr  input  32  RV32I instruction word.
REQ-007 out_valid  output  1  decoded bundle valid.
REQ-008 out_ready  input  1  downstream (ALU issue) accepts bundle.
REQ-009 alu_op  output  alu_instruction_t  ALU operation.
REQ-010 imm12  output  imm12_t  immediate for ALU or branch.
REQ-011 rs1_addr, rs2_addr, rd_addr  output  REG_ADDR_W each  register indices.
REQ-012 rd_we  output  1  result is written back.
REQ-013 is_branch  output  1  op is BEQ/BNE/BLT/BGE.
REQ-014 err  output  1  decoder halted on an illegal instruction.
REQ-015 err_instr  output  32  offending instruction word.
REQ-016 clear_err  input  1  leaves HALT.

Function
REQ-017 Decoder SHALL be a 3-state FSM: EMPTY, FULL, HALT.
REQ-018 in_ready SHALL be 1 in EMPTY, (out_ready) in FULL, 0 in HALT; out_valid SHALL be 1 only in FULL.
REQ-019 A transfer SHALL occur when in_valid and in_ready are both 1; a legal accepted instr SHALL appear on outputs with out_valid=1 the next cycle (latency 1, throughput 1/cycle).
REQ-020 In FULL, outputs SHALL hold stable while out_ready=0.
REQ-021 FULL with out_ready=1 and no new legal input SHALL go EMPTY; with a new legal input SHALL reload and stay FULL.
REQ-022 OP-IMM (0010011) funct3: 000 ADDI, 010 SLTI, 100 XORI, 110 ORI, 111 ANDI, 001 SLLI (funct7=0000000), 101 SRLI (funct7=0000000) / SRAI (funct7=0100000); imm12=instr[31:20], except shifts where imm12={7'b0, instr[24:20]}.
REQ-023 OP (0110011) funct3/funct7: 000 ADD(0000000)/SUB(0100000), 001 SLL, 010 SLT, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND; imm12=0.
REQ-024 BRANCH (1100011) funct3: 000 BEQ, 001 BNE, 100 BLT, 101 BGE; imm12={instr[31],instr[7],instr[30:25],instr[11:8]} (imm[12:1]); is_branch=1, rd_we=0, rd_addr=0.
REQ-025 rd_we SHALL be 1 for OP/OP-IMM when rd_addr!=0, else 0.
REQ-026 Any other opcode, funct3 011 on OP/OP-IMM, funct3 010/011/110/111 on BRANCH, or a disallowed funct7 SHALL be illegal.
REQ-027 An accepted illegal instr SHALL not be forwarded; next state HALT, err=1, err_instr=instr; a bundle in FULL handed off that same cycle (out_ready=1) SHALL complete normally.
REQ-028 In HALT, clear_err=1 SHALL go EMPTY and clear err next cycle; err_instr SHALL hold until the next illegal instr; clear_err outside HALT SHALL be ignored.

Reset
REQ-029 Reset SHALL force EMPTY, out_valid=0, alu_op=ADDI, imm12=0, all addrs 0, rd_we=0, is_branch=0, err=0, err_instr=0.
REQ-030 Reset mid-operation SHALL discard any held bundle and HALT condition, with reset taking priority over every other input.

Structure
REQ-031 alu_instruction_t, imm12_t, data_t and opcode/funct3/funct7 localparams SHALL live in common.sv.
REQ-032 Pure decode logic SHALL be a combinational sub-module instr_decode_comb (instr -> bundle + illegal); FSM and output register in instr_decoder.

Verification
REQ-033 instr=0xFFB10093 -> next cycle alu_op=ADDI, imm12=0xFFB, rs1_addr=2, rd_addr=1, rd_we=1, is_branch=0.
REQ-034 instr=0x405201B3 -> alu_op=SUB, rs1_addr=4, rs2_addr=5, rd_addr=3, rd_we=1, imm12=0.
REQ-035 instr=0x00209463 -> alu_op=BNE, imm12=0x004, rs1_addr=1, rs2_addr=2, is_branch=1, rd_we=0.
REQ-036 Three back-to-back legal instrs with out_ready=0 for 3 cycles -> first bundle stable, in_ready=0, then all three delivered in order, none lost or duplicated.
REQ-037 instr=0x00003013 (SLTIU) -> no out_valid, err=1, err_instr=0x00003013, in_ready=0 until clear_err pulse, then EMPTY.
REQ-038 reset asserted while FULL and out_ready=0 -> next cycle out_valid=0, in_ready=1, all outputs at reset values.

Source files
------------

// File: rtl/common.sv
// Shared types and encodings for the RV32I integer decode path.
package common;

   typedef logic [31:0] data_t;
   typedef logic [11:0] imm12_t;

   // ALU operations; ADDI is the reset / idle value of the decoded bundle
   typedef enum logic [4:0] {
      ALU_ADDI = 5'd0,
      ALU_SLTI,
      ALU_XORI,
      ALU_ORI,
      ALU_ANDI,
      ALU_SLLI,
      ALU_SRLI,
      ALU_SRAI,
      ALU_ADD,
      ALU_SUB,
      ALU_SLL,
      ALU_SLT,
      ALU_XOR,
      ALU_SRL,
      ALU_SRA,
      ALU_OR,
      ALU_AND,
      ALU_BEQ,
      ALU_BNE,
      ALU_BLT,
      ALU_BGE
   } alu_instruction_t;

   // Decoder handshake states
   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_FULL,
      ST_HALT
   } dec_state_t;

   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   // Branch offset bits imm[12:1] gathered from the B-type fields
   function automatic imm12_t branch_imm(input data_t word);
      return {word[31], word[7], word[30:25], word[11:8]};
   endfunction

   // Shift amount zero-extended into the 12-bit immediate slot
   function automatic imm12_t shamt_imm(input data_t word);
      return {7'b0000000, word[24:20]};
   endfunction

endpackage

// File: rtl/instr_decode_comb.sv
// Pure combinational RV32I decode of OP, OP-IMM and BRANCH words into an ALU bundle.
module instr_decode_comb
   import common::*;
#(
   parameter int REG_ADDR_W = 5
) (
   input  logic [31:0]           instr,
   output alu_instruction_t      alu_op,
   output imm12_t                imm12,
   output logic [REG_ADDR_W-1:0] rs1_addr,
   output logic [REG_ADDR_W-1:0] rs2_addr,
   output logic [REG_ADDR_W-1:0] rd_addr,
   output logic                  rd_we,
   output logic                  is_branch,
   output logic                  illegal
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];

   // Field extraction and legality check per opcode class; anything unmatched is illegal
   always_comb begin
      alu_op    = ALU_ADDI;
      imm12     = '0;
      rs1_addr  = '0;
      rs2_addr  = '0;
      rd_addr   = '0;
      rd_we     = 1'b0;
      is_branch = 1'b0;
      illegal   = 1'b0;
      case (opcode)
         OPC_OP_IMM: begin
            rs1_addr = REG_ADDR_W'(instr[19:15]);
            rd_addr  = REG_ADDR_W'(instr[11:7]);
            rd_we    = (rd_addr != '0);
            imm12    = instr[31:20];
            case (funct3)
               F3_ADD: alu_op = ALU_ADDI;
               F3_SLT: alu_op = ALU_SLTI;
               F3_XOR: alu_op = ALU_XORI;
               F3_OR:  alu_op = ALU_ORI;
               F3_AND: alu_op = ALU_ANDI;
               F3_SLL: begin
                  alu_op  = ALU_SLLI;
                  imm12   = shamt_imm(instr);
                  illegal = (funct7 != F7_BASE);
               end
               F3_SR: begin
                  imm12 = shamt_imm(instr);
                  if (funct7 == F7_BASE) begin
                     alu_op = ALU_SRLI;
                  end else if (funct7 == F7_ALT) begin
                     alu_op = ALU_SRAI;
                  end else begin
                     illegal = 1'b1;
                  end
               end
               default: illegal = 1'b1;
            endcase
         end
         OPC_OP: begin
            rs1_addr = REG_ADDR_W'(instr[19:15]);
            rs2_addr = REG_ADDR_W'(instr[24:20]);
            rd_addr  = REG_ADDR_W'(instr[11:7]);
            rd_we    = (rd_addr != '0);
            case (funct3)
               F3_ADD: begin
                  if (funct7 == F7_BASE) begin
                     alu_op = ALU_ADD;
                  end else if (funct7 == F7_ALT) begin
                     alu_op = ALU_SUB;
                  end else begin
                     illegal = 1'b1;
                  end
               end
               F3_SR: begin
                  if (funct7 == F7_BASE) begin
                     alu_op = ALU_SRL;
                  end else if (funct7 == F7_ALT) begin
                     alu_op = ALU_SRA;
                  end else begin
                     illegal = 1'b1;
                  end
               end
               F3_SLL: begin
                  alu_op  = ALU_SLL;
                  illegal = (funct7 != F7_BASE);
               end
               F3_SLT: begin
                  alu_op  = ALU_SLT;
                  illegal = (funct7 != F7_BASE);
               end
               F3_XOR: begin
                  alu_op  = ALU_XOR;
                  illegal = (funct7 != F7_BASE);
               end
               F3_OR: begin
                  alu_op  = ALU_OR;
                  illegal = (funct7 != F7_BASE);
               end
               F3_AND: begin
                  alu_op  = ALU_AND;
                  illegal = (funct7 != F7_BASE);
               end
               default: illegal = 1'b1;
            endcase
         end
         OPC_BRANCH: begin
            rs1_addr  = REG_ADDR_W'(instr[19:15]);
            rs2_addr  = REG_ADDR_W'(instr[24:20]);
            imm12     = branch_imm(instr);
            is_branch = 1'b1;
            case (funct3)
               F3_BEQ:  alu_op = ALU_BEQ;
               F3_BNE:  alu_op = ALU_BNE;
               F3_BLT:  alu_op = ALU_BLT;
               F3_BGE:  alu_op = ALU_BGE;
               default: illegal = 1'b1;
            endcase
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_decoder.sv
// Single-entry decode stage: valid/ready handshake, registered bundle, halt on illegal words.
module instr_decoder
   import common::*;
#(
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [31:0]           instr,
   output logic                  out_valid,
   input  logic                  out_ready,
   output alu_instruction_t      alu_op,
   output imm12_t                imm12,
   output logic [REG_ADDR_W-1:0] rs1_addr,
   output logic [REG_ADDR_W-1:0] rs2_addr,
   output logic [REG_ADDR_W-1:0] rd_addr,
   output logic                  rd_we,
   output logic                  is_branch,
   output logic                  err,
   output logic [31:0]           err_instr,
   input  logic                  clear_err
);

   dec_state_t            state_q, state_d;
   alu_instruction_t      alu_op_q, alu_op_d;
   imm12_t                imm12_q, imm12_d;
   logic [REG_ADDR_W-1:0] rs1_addr_q, rs1_addr_d;
   logic [REG_ADDR_W-1:0] rs2_addr_q, rs2_addr_d;
   logic [REG_ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic                  rd_we_q, rd_we_d;
   logic                  is_branch_q, is_branch_d;
   logic [31:0]           err_instr_q, err_instr_d;

   alu_instruction_t      dec_alu_op;
   imm12_t                dec_imm12;
   logic [REG_ADDR_W-1:0] dec_rs1_addr;
   logic [REG_ADDR_W-1:0] dec_rs2_addr;
   logic [REG_ADDR_W-1:0] dec_rd_addr;
   logic                  dec_rd_we;
   logic                  dec_is_branch;
   logic                  dec_illegal;
   logic                  accept;
   logic                  load;

   instr_decode_comb #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_decode (
      .instr     (instr),
      .alu_op    (dec_alu_op),
      .imm12     (dec_imm12),
      .rs1_addr  (dec_rs1_addr),
      .rs2_addr  (dec_rs2_addr),
      .rd_addr   (dec_rd_addr),
      .rd_we     (dec_rd_we),
      .is_branch (dec_is_branch),
      .illegal   (dec_illegal)
   );

   // Ready is free when empty, follows downstream when full, and is held off while halted
   always_comb begin
      in_ready = 1'b0;
      case (state_q)
         ST_EMPTY: in_ready = 1'b1;
         ST_FULL:  in_ready = out_ready;
         default:  in_ready = 1'b0;
      endcase
   end

   assign accept = in_valid & in_ready;

   // Next state, bundle reload and error capture; an illegal accept never reaches the bundle
   always_comb begin
      state_d     = state_q;
      err_instr_d = err_instr_q;
      load        = 1'b0;
      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               if (dec_illegal) begin
                  state_d     = ST_HALT;
                  err_instr_d = instr;
               end else begin
                  state_d = ST_FULL;
                  load    = 1'b1;
               end
            end
         end
         ST_FULL: begin
            if (accept) begin
               if (dec_illegal) begin
                  state_d     = ST_HALT;
                  err_instr_d = instr;
               end else begin
                  load = 1'b1;
               end
            end else if (out_ready) begin
               state_d = ST_EMPTY;
            end
         end
         ST_HALT: begin
            if (clear_err) begin
               state_d = ST_EMPTY;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   // Bundle register input: take the fresh decode on a legal accept, otherwise hold
   always_comb begin
      alu_op_d    = alu_op_q;
      imm12_d     = imm12_q;
      rs1_addr_d  = rs1_addr_q;
      rs2_addr_d  = rs2_addr_q;
      rd_addr_d   = rd_addr_q;
      rd_we_d     = rd_we_q;
      is_branch_d = is_branch_q;
      if (load) begin
         alu_op_d    = dec_alu_op;
         imm12_d     = dec_imm12;
         rs1_addr_d  = dec_rs1_addr;
         rs2_addr_d  = dec_rs2_addr;
         rd_addr_d   = dec_rd_addr;
         rd_we_d     = dec_rd_we;
         is_branch_d = dec_is_branch;
      end
   end

   // State and output registers; reset wins over every other input
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_EMPTY;
         alu_op_q    <= ALU_ADDI;
         imm12_q     <= '0;
         rs1_addr_q  <= '0;
         rs2_addr_q  <= '0;
         rd_addr_q   <= '0;
         rd_we_q     <= 1'b0;
         is_branch_q <= 1'b0;
         err_instr_q <= '0;
      end else begin
         state_q     <= state_d;
         alu_op_q    <= alu_op_d;
         imm12_q     <= imm12_d;
         rs1_addr_q  <= rs1_addr_d;
         rs2_addr_q  <= rs2_addr_d;
         rd_addr_q   <= rd_addr_d;
         rd_we_q     <= rd_we_d;
         is_branch_q <= is_branch_d;
         err_instr_q <= err_instr_d;
      end
   end

   assign out_valid = (state_q == ST_FULL);
   assign err       = (state_q == ST_HALT);
   assign err_instr = err_instr_q;
   assign alu_op    = alu_op_q;
   assign imm12     = imm12_q;
   assign rs1_addr  = rs1_addr_q;
   assign rs2_addr  = rs2_addr_q;
   assign rd_addr   = rd_addr_q;
   assign rd_we     = rd_we_q;
   assign is_branch = is_branch_q;

endmodule

// File: tb/tb_instr_decoder.sv
// Self-checking bench for instr_decoder: directed cases plus randomized traffic vs a queue model.
module tb_instr_decoder;
   import common::*;

   typedef struct packed {
      alu_instruction_t op;
      logic [11:0]      imm;
      logic [4:0]       rs1;
      logic [4:0]       rs2;
      logic [4:0]       rd;
      logic             we;
      logic             br;
   } bundle_t;

   localparam bundle_t RESET_B = '{ALU_ADDI, 12'h000, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0};

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      instr;
   logic             out_valid;
   logic             out_ready;
   alu_instruction_t alu_op;
   imm12_t           imm12;
   logic [4:0]       rs1_addr;
   logic [4:0]       rs2_addr;
   logic [4:0]       rd_addr;
   logic             rd_we;
   logic             is_branch;
   logic             err;
   logic [31:0]      err_instr;
   logic             clear_err;

   int errors = 0;
   int checks = 0;

   // Reference model: at most one pending bundle, plus a halted flag and last bad word
   bundle_t     exp_q[$];
   bit          halted;
   logic [31:0] exp_err_instr;
   bit          seen_in_ready;
   bit          want_in_ready;

   alu_instruction_t opimm_tab[8] = '{ALU_ADDI, ALU_SLLI, ALU_SLTI, ALU_ADDI,
                                      ALU_XORI, ALU_SRLI, ALU_ORI, ALU_ANDI};
   alu_instruction_t op_tab[8]    = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_ADD,
                                      ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
   alu_instruction_t br_tab[8]    = '{ALU_BEQ, ALU_BNE, ALU_BEQ, ALU_BEQ,
                                      ALU_BLT, ALU_BGE, ALU_BEQ, ALU_BEQ};

   always #5 clk = ~clk;

   instr_decoder #(.REG_ADDR_W(5)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .instr     (instr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .alu_op    (alu_op),
      .imm12     (imm12),
      .rs1_addr  (rs1_addr),
      .rs2_addr  (rs2_addr),
      .rd_addr   (rd_addr),
      .rd_we     (rd_we),
      .is_branch (is_branch),
      .err       (err),
      .err_instr (err_instr),
      .clear_err (clear_err)
   );

   // Table-driven decode of a word straight from the ISA rules
   function automatic void ref_decode(input logic [31:0] w, output bit legal, output bundle_t b);
      logic [6:0] opc;
      logic [2:0] f3;
      logic [6:0] f7;
      opc   = w[6:0];
      f3    = w[14:12];
      f7    = w[31:25];
      b     = RESET_B;
      legal = 1'b0;
      if (opc == 7'h13) begin
         legal = (f3 != 3'd3);
         if (f3 == 3'd1) legal = (f7 == 7'h00);
         if (f3 == 3'd5) legal = (f7 == 7'h00) || (f7 == 7'h20);
         b.op  = (f3 == 3'd5 && f7 == 7'h20) ? ALU_SRAI : opimm_tab[f3];
         b.imm = (f3 == 3'd1 || f3 == 3'd5) ? {7'd0, w[24:20]} : w[31:20];
         b.rs1 = w[19:15];
         b.rd  = w[11:7];
         b.we  = (w[11:7] != 5'd0);
      end else if (opc == 7'h33) begin
         legal = (f3 != 3'd3) && ((f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
         b.op  = op_tab[f3];
         if (f7 == 7'h20) b.op = (f3 == 3'd0) ? ALU_SUB : ALU_SRA;
         b.rs1 = w[19:15];
         b.rs2 = w[24:20];
         b.rd  = w[11:7];
         b.we  = (w[11:7] != 5'd0);
      end else if (opc == 7'h63) begin
         legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd4) || (f3 == 3'd5);
         b.op  = br_tab[f3];
         b.imm = {w[31], w[7], w[30:25], w[11:8]};
         b.rs1 = w[19:15];
         b.rs2 = w[24:20];
         b.br  = 1'b1;
      end
   endfunction

   function automatic bundle_t observe();
      return '{alu_op, imm12, rs1_addr, rs2_addr, rd_addr, rd_we, is_branch};
   endfunction

   function automatic bundle_t expect_of(input logic [31:0] w);
      bit      lg;
      bundle_t b;
      ref_decode(w, lg, b);
      return b;
   endfunction

   // Mostly-legal random words, with occasional bad funct3/funct7 or foreign opcodes
   function automatic logic [31:0] gen_instr();
      logic [31:0] w;
      int          sel;
      logic [2:0]  f3;
      w   = $urandom;
      sel = $urandom_range(0, 15);
      f3  = w[14:12];
      if (sel < 5) begin
         w[6:0] = 7'h13;
         if (f3 == 3'd1 || f3 == 3'd5)
            w[31:25] = ($urandom_range(0, 9) == 0) ? 7'($urandom) :
                       ($urandom_range(0, 1) == 1 ? 7'h20 : 7'h00);
      end else if (sel < 10) begin
         w[6:0]   = 7'h33;
         w[31:25] = ($urandom_range(0, 9) == 0) ? 7'($urandom) :
                    ($urandom_range(0, 1) == 1 ? 7'h20 : 7'h00);
      end else if (sel < 14) begin
         w[6:0] = 7'h63;
         if ($urandom_range(0, 7) != 0) begin
            case ($urandom_range(0, 3))
               0:       w[14:12] = 3'd0;
               1:       w[14:12] = 3'd1;
               2:       w[14:12] = 3'd4;
               default: w[14:12] = 3'd5;
            endcase
         end
      end
      return w;
   endfunction

   // One clock of stimulus, driven at the falling edge; model advances alongside
   task automatic step(input bit v, input logic [31:0] ins, input bit ordy, input bit clr);
      bit      lg;
      bundle_t b;
      in_valid  = v;
      instr     = ins;
      out_ready = ordy;
      clear_err = clr;
      #1;
      seen_in_ready = in_ready;
      want_in_ready = !halted && (exp_q.size() == 0 || ordy);
      ref_decode(ins, lg, b);
      if (halted) begin
         if (clr) halted = 1'b0;
      end else begin
         if (exp_q.size() != 0 && ordy) void'(exp_q.pop_front());
         if (v && want_in_ready) begin
            if (lg) begin
               exp_q.push_back(b);
            end else begin
               halted        = 1'b1;
               exp_err_instr = ins;
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset(input bit v, input logic [31:0] ins, input bit ordy);
      reset     = 1'b1;
      in_valid  = v;
      instr     = ins;
      out_ready = ordy;
      clear_err = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset     = 1'b0;
      in_valid  = 1'b0;
      clear_err = 1'b0;
      exp_q.delete();
      halted        = 1'b0;
      exp_err_instr = 32'h0;
   endtask

   task automatic test_reset();
      do_reset(1'b0, 32'h0, 1'b0);
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
      checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b want 0", err); end
      checks++; if (err_instr !== 32'h0) begin errors++; $display("[TB] FAIL reset_err_instr: got %h want 0", err_instr); end
      checks++; if (observe() !== RESET_B) begin errors++; $display("[TB] FAIL reset_bundle: got %h want %h", observe(), RESET_B); end
   endtask

   task automatic test_directed();
      logic [31:0] words[4] = '{32'hFFB10093, 32'h405201B3, 32'h00209463, 32'h00000013};
      bundle_t     want[4]  = '{'{ALU_ADDI, 12'hFFB, 5'd2, 5'd0, 5'd1, 1'b1, 1'b0},
                                '{ALU_SUB,  12'h000, 5'd4, 5'd5, 5'd3, 1'b1, 1'b0},
                                '{ALU_BNE,  12'h004, 5'd1, 5'd2, 5'd0, 1'b0, 1'b1},
                                '{ALU_ADDI, 12'h000, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0}};
      for (int i = 0; i < 4; i++) begin
         step(1'b1, words[i], 1'b0, 1'b0);
         checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL directed%0d_valid: got %b want 1", i, out_valid); end
         checks++; if (observe() !== want[i]) begin errors++; $display("[TB] FAIL directed%0d_bundle: got %h want %h", i, observe(), want[i]); end
         step(1'b0, 32'h0, 1'b1, 1'b0);
         checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL directed%0d_drain: got %b want 0", i, out_valid); end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a = 32'h00A00093;
      logic [31:0] b = 32'h002081B3;
      logic [31:0] c = 32'h00208463;
      step(1'b1, a, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, b, 1'b0, 1'b0);
         checks++; if (seen_in_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_stall_ready%0d: got %b want 0", i, seen_in_ready); end
         checks++; if (observe() !== expect_of(a) || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_hold%0d: got %h want %h", i, observe(), expect_of(a)); end
      end
      step(1'b1, b, 1'b1, 1'b0);
      checks++; if (seen_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_release_ready: got %b want 1", seen_in_ready); end
      checks++; if (observe() !== expect_of(b) || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_second: got %h want %h", observe(), expect_of(b)); end
      step(1'b1, c, 1'b1, 1'b0);
      checks++; if (observe() !== expect_of(c) || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_third: got %h want %h", observe(), expect_of(c)); end
      step(1'b0, 32'h0, 1'b1, 1'b0);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_empty: got %b want 0", out_valid); end
   endtask

   task automatic test_illegal();
      step(1'b1, 32'h00003013, 1'b1, 1'b0);
      checks++; if (out_valid !== 1'b0 || err !== 1'b1) begin errors++; $display("[TB] FAIL illegal_halt: got valid=%b err=%b want valid=0 err=1", out_valid, err); end
      checks++; if (err_instr !== 32'h00003013) begin errors++; $display("[TB] FAIL illegal_word: got %h want 00003013", err_instr); end
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 32'h00100093, 1'b1, 1'b0);
         checks++; if (seen_in_ready !== 1'b0 || out_valid !== 1'b0 || err !== 1'b1) begin errors++; $display("[TB] FAIL illegal_stuck%0d: got ready=%b valid=%b err=%b want 0 0 1", i, seen_in_ready, out_valid, err); end
      end
      step(1'b0, 32'h0, 1'b1, 1'b1);
      checks++; if (err !== 1'b0 || err_instr !== 32'h00003013) begin errors++; $display("[TB] FAIL illegal_clear: got err=%b word=%h want err=0 word=00003013", err, err_instr); end
      step(1'b1, 32'h00100093, 1'b0, 1'b1);
      checks++; if (seen_in_ready !== 1'b1 || out_valid !== 1'b1 || err !== 1'b0) begin errors++; $display("[TB] FAIL clear_outside_halt: got ready=%b valid=%b err=%b want 1 1 0", seen_in_ready, out_valid, err); end
      step(1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
      checks++; if (out_valid !== 1'b0 || err !== 1'b1 || err_instr !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL illegal_from_full: got valid=%b err=%b word=%h want 0 1 ffffffff", out_valid, err, err_instr); end
      step(1'b0, 32'h0, 1'b0, 1'b1);
   endtask

   task automatic test_reset_mid();
      step(1'b1, 32'h405201B3, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0);
      do_reset(1'b1, 32'h00209463, 1'b0);
      #1;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_full: got valid=%b ready=%b want 0 1", out_valid, in_ready); end
      checks++; if (observe() !== RESET_B) begin errors++; $display("[TB] FAIL reset_full_bundle: got %h want %h", observe(), RESET_B); end
      step(1'b1, 32'h0000F013, 1'b0, 1'b0);
      do_reset(1'b1, 32'h00100093, 1'b1);
      #1;
      checks++; if (err !== 1'b0 || err_instr !== 32'h0 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_halt: got err=%b word=%h valid=%b want 0 0 0", err, err_instr, out_valid); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 600; n++) begin
         step($urandom_range(0, 3) != 0, gen_instr(), $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0);
         checks++; if (seen_in_ready !== want_in_ready) begin errors++; $display("[TB] FAIL rand_in_ready@%0d: got %b want %b", n, seen_in_ready, want_in_ready); end
         checks++; if (out_valid !== (exp_q.size() != 0)) begin errors++; $display("[TB] FAIL rand_out_valid@%0d: got %b want %b", n, out_valid, exp_q.size() != 0); end
         checks++; if (err !== halted || err_instr !== exp_err_instr) begin errors++; $display("[TB] FAIL rand_err@%0d: got %b/%h want %b/%h", n, err, err_instr, halted, exp_err_instr); end
         if (exp_q.size() != 0) begin
            checks++; if (observe() !== exp_q[0]) begin errors++; $display("[TB] FAIL rand_bundle@%0d: got %h want %h", n, observe(), exp_q[0]); end
         end
      end
   endtask

   initial begin
      reset         = 1'b1;
      in_valid      = 1'b0;
      instr         = 32'h0;
      out_ready     = 1'b0;
      clear_err     = 1'b0;
      halted        = 1'b0;
      exp_err_instr = 32'h0;
      @(negedge clk);
      test_reset();
      test_directed();
      test_back_to_back();
      test_illegal();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
